// File: rtl/branch_pred_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_pkg
//  Description : Shared types and constants for the fetch-side branch
//                predictor (BTB entry layout, direction counter encodings,
//                associativity) plus the saturating counter step helper.
//  Revision    : 1.0  initial release
// ============================================================================
package branch_pred_pkg;

  localparam int BTB_WAYS    = 4;
  // Widest PC the entry layout can hold; narrower PCs are zero-extended.
  localparam int BP_ADDR_MAX = 64;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                   valid;
    logic [BP_ADDR_MAX-1:0] tag;
    logic [BP_ADDR_MAX-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  localparam btb_entry_t C_ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  // Two-bit saturating counter: step toward ST on taken, toward SNT otherwise.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nxt = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_pred_unit_plru.sv
`default_nettype none
// ============================================================================
//  Module      : plru_4way
//  Description : Combinational 4-way tree pseudo-LRU helper.
//                Picks a victim (lowest invalid way first, else the tree
//                choice) and computes the tree state after touching a way.
//  Ports       : i_plru[2:0]      current tree bits {b2,b1,b0}
//                i_valid[3:0]     per-way valid bits of the set
//                i_way[1:0]       way being accessed
//                o_victim[1:0]    replacement victim
//                o_plru_next[2:0] tree bits after touching i_way
//  Revision    : 1.0  initial release
// ============================================================================
module plru_4way (
  input  logic [2:0] i_plru,
  input  logic [3:0] i_valid,
  input  logic [1:0] i_way,
  output logic [1:0] o_victim,
  output logic [2:0] o_plru_next
);

  always_comb begin
    o_victim = 2'd0;
    if (!i_valid[0]) begin
      o_victim = 2'd0;
    end else if (!i_valid[1]) begin
      o_victim = 2'd1;
    end else if (!i_valid[2]) begin
      o_victim = 2'd2;
    end else if (!i_valid[3]) begin
      o_victim = 2'd3;
    end else if (!i_plru[0]) begin
      o_victim = {1'b0, i_plru[1]};
    end else begin
      o_victim = {1'b1, i_plru[2]};
    end
  end

  // Touching a way points b0 at the other half and the half's bit at the
  // sibling way, so the touched way is the last one to be chosen.
  always_comb begin
    o_plru_next = i_plru;
    case (i_way)
      2'd0: begin o_plru_next[0] = 1'b1; o_plru_next[1] = 1'b1; end
      2'd1: begin o_plru_next[0] = 1'b1; o_plru_next[1] = 1'b0; end
      2'd2: begin o_plru_next[0] = 1'b0; o_plru_next[2] = 1'b1; end
      default: begin o_plru_next[0] = 1'b0; o_plru_next[2] = 1'b0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pred_unit
//  Description : Fetch-side branch predictor. 4-way set-associative BTB with
//                a 2-bit direction counter per entry and tree PLRU per set.
//                Lookup is combinational from i_pc; training happens on the
//                rising clock edge from execute-stage resolutions.
//  Ports       : i_clk, i_arstn            clock, async active-low reset
//                i_pc                      fetch PC to predict
//                o_branch_pred_taken       predicted taken
//                o_pc_target_addr_pred     predicted target (0 on miss)
//                o_btb_way                 hit way, else replacement victim
//                i_branch_exec             resolution strobe
//                i_branch_taken_exec       resolved direction
//                i_pc_exec                 resolved instruction PC
//                i_pc_target_addr          resolved target
//                i_btb_way_exec            way reported at fetch
//  Revision    : 1.0  initial release
// ============================================================================
module branch_pred_unit
  import branch_pred_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SET_COUNT  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic                  o_branch_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pc_target_addr_pred,
  output logic [1:0]            o_btb_way,
  input  logic                  i_branch_exec,
  input  logic                  i_branch_taken_exec,
  input  logic [ADDR_WIDTH-1:0] i_pc_exec,
  input  logic [ADDR_WIDTH-1:0] i_pc_target_addr,
  input  logic [1:0]            i_btb_way_exec
);

  localparam int INDEX_W = $clog2(SET_COUNT);

  btb_entry_t btb_q [SET_COUNT][BTB_WAYS];
  btb_entry_t btb_d [SET_COUNT][BTB_WAYS];
  logic [2:0] plru_q [SET_COUNT];
  logic [2:0] plru_d [SET_COUNT];

  // ---------------------------------------------------------------- lookup
  logic [INDEX_W-1:0]     w_lk_idx;
  logic [BP_ADDR_MAX-1:0] w_lk_tag;
  logic [BTB_WAYS-1:0]    w_lk_valid;
  logic                   w_lk_hit;
  logic [1:0]             w_lk_hit_way;
  logic [1:0]             w_lk_victim;
  logic [2:0]             w_lk_plru_next;
  btb_entry_t             w_lk_entry;

  assign w_lk_idx = i_pc[INDEX_W+1:2];
  assign w_lk_tag = BP_ADDR_MAX'(i_pc[ADDR_WIDTH-1:INDEX_W+2]);

  // Descending scan so the lowest matching way wins if duplicates ever exist.
  always_comb begin
    w_lk_hit     = 1'b0;
    w_lk_hit_way = 2'd0;
    w_lk_valid   = '0;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      w_lk_valid[w] = btb_q[w_lk_idx][w].valid;
      if (btb_q[w_lk_idx][w].valid && (btb_q[w_lk_idx][w].tag == w_lk_tag)) begin
        w_lk_hit     = 1'b1;
        w_lk_hit_way = 2'(w);
      end
    end
  end

  plru_4way u_plru_lookup (
    .i_plru      (plru_q[w_lk_idx]),
    .i_valid     (w_lk_valid),
    .i_way       (2'd0),
    .o_victim    (w_lk_victim),
    .o_plru_next (w_lk_plru_next)
  );

  assign w_lk_entry            = btb_q[w_lk_idx][w_lk_hit_way];
  assign o_branch_pred_taken   = w_lk_hit & w_lk_entry.ctr[1];
  assign o_pc_target_addr_pred = w_lk_hit ? w_lk_entry.target[ADDR_WIDTH-1:0] : '0;
  assign o_btb_way             = w_lk_hit ? w_lk_hit_way : w_lk_victim;

  // ---------------------------------------------------------------- update
  logic [INDEX_W-1:0]     w_up_idx;
  logic [BP_ADDR_MAX-1:0] w_up_tag;
  logic [BP_ADDR_MAX-1:0] w_up_target;
  logic [BTB_WAYS-1:0]    w_up_valid;
  btb_entry_t             w_up_entry;
  logic                   w_up_match;
  logic [2:0]             w_up_plru_next;
  logic [1:0]             w_up_victim;

  assign w_up_idx    = i_pc_exec[INDEX_W+1:2];
  assign w_up_tag    = BP_ADDR_MAX'(i_pc_exec[ADDR_WIDTH-1:INDEX_W+2]);
  assign w_up_target = BP_ADDR_MAX'(i_pc_target_addr);
  assign w_up_entry  = btb_q[w_up_idx][i_btb_way_exec];
  assign w_up_match  = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

  always_comb begin
    w_up_valid = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      w_up_valid[w] = btb_q[w_up_idx][w].valid;
    end
  end

  plru_4way u_plru_update (
    .i_plru      (plru_q[w_up_idx]),
    .i_valid     (w_up_valid),
    .i_way       (i_btb_way_exec),
    .o_victim    (w_up_victim),
    .o_plru_next (w_up_plru_next)
  );

  always_comb begin
    btb_d  = btb_q;
    plru_d = plru_q;
    if (i_branch_exec) begin
      if (w_up_match) begin
        btb_d[w_up_idx][i_btb_way_exec].ctr = ctr_step(w_up_entry.ctr, i_branch_taken_exec);
        if (i_branch_taken_exec) begin
          btb_d[w_up_idx][i_btb_way_exec].target = w_up_target;
        end
        plru_d[w_up_idx] = w_up_plru_next;
      end else if (i_branch_taken_exec) begin
        // Fresh allocations start weakly taken.
        btb_d[w_up_idx][i_btb_way_exec] = '{valid: 1'b1, tag: w_up_tag,
                                            target: w_up_target, ctr: CTR_WT};
        plru_d[w_up_idx] = w_up_plru_next;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        plru_q[s] <= 3'b000;
        for (int w = 0; w < BTB_WAYS; w++) begin
          btb_q[s][w] <= C_ENTRY_RST;
        end
      end
    end else begin
      btb_q  <= btb_d;
      plru_q <= plru_d;
    end
  end

  // Byte-offset bits and the helper outputs each instance does not need.
  logic w_unused;
  assign w_unused = ^{i_pc[1:0], i_pc_exec[1:0], w_lk_plru_next, w_up_victim};

endmodule
`default_nettype wire
